// File: rtl/slot_io_pkg.sv
// Shared definitions for the slot I/O responder: register map, STATUS/CTRL bit
// positions and the access FSM encoding.
package slot_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BANK   = 2'd3;

    localparam int ST_RX_NE  = 0;
    localparam int ST_TX_NF  = 1;
    localparam int ST_TX_OVR = 2;
    localparam int ST_RX_UNF = 3;
    localparam int ST_IRQ    = 7;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_FLUSH = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/slot_fifo.sv
// Synchronous FIFO with flush; the head is read combinationally so that the
// stream valid and data appear together.
module slot_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A flush wins over any transfer requested in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/slot_io_responder.sv
// Card-side slot responder: synchronizes the CPU strobe, serves a four-register
// window and bridges it to a local byte-stream device through two FIFOs.
module slot_io_responder
    import slot_io_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int ROM_BANK_BITS = 3,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       SYSCLK,
    input  logic                       nRST,
    input  logic                       SLOT_IOSEL,
    input  logic                       SLOT_ROMSEL,
    input  logic [7:0]                 CPU_A,
    input  logic [7:0]                 CPU_D_IN,
    input  logic                       CPU_RW,
    output logic [7:0]                 CPU_D_OUT,
    output logic                       CPU_D_OE,
    output logic [8+ROM_BANK_BITS-1:0] ROM_A,
    output logic                       ROM_nCE,
    output logic                       nIRQ,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready
);

    logic       sel_s1_q, sel_s2_q, sel_d_q;
    logic [1:0] a_s1_q, a_s2_q;
    logic       rw_s1_q, rw_s2_q;
    logic [7:0] din_s1_q, din_s2_q;

    state_t     state_q, state_d;
    logic [1:0] addr_q;
    logic       rw_q;
    logic [7:0] din_q;
    logic [7:0] dout_q;
    logic       rx_seen_q;
    logic [1:0] ie_q;
    logic [ROM_BANK_BITS-1:0] bank_q;
    logic       tx_ovr_q, rx_unf_q, irq_q;

    logic       sel_rise, sel_fall, commit_fire, wr_commit, rd_commit;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_flush;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic       unused_counts;
    logic [7:0] status_byte, bank_byte, rd_mux;
    logic       irq_d;

    // Synchronizer flops reset high: a strobe already asserted when reset is
    // released must not be mistaken for a fresh rising edge.
    always_ff @(posedge SYSCLK or negedge nRST) begin
        if (!nRST) begin
            sel_s1_q <= 1'b1;
            sel_s2_q <= 1'b1;
            sel_d_q  <= 1'b1;
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            rw_s1_q  <= 1'b0;
            rw_s2_q  <= 1'b0;
            din_s1_q <= '0;
            din_s2_q <= '0;
        end else begin
            sel_s1_q <= SLOT_IOSEL;
            sel_s2_q <= sel_s1_q;
            sel_d_q  <= sel_s2_q;
            a_s1_q   <= CPU_A[1:0];
            a_s2_q   <= a_s1_q;
            rw_s1_q  <= CPU_RW;
            rw_s2_q  <= rw_s1_q;
            din_s1_q <= CPU_D_IN;
            din_s2_q <= din_s1_q;
        end
    end

    assign sel_rise = sel_s2_q && !sel_d_q;
    assign sel_fall = !sel_s2_q && sel_d_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_rise) state_d = ACTIVE;
            ACTIVE:  if (sel_fall) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Side effects fire on the edge that enters COMMIT so that they land on the
    // third edge after the strobe falls; COMMIT itself is a one-cycle gap.
    assign commit_fire = (state_q == ACTIVE) && sel_fall;
    assign wr_commit   = commit_fire && !rw_q;
    assign rd_commit   = commit_fire && rw_q;

    assign tx_push  = wr_commit && (addr_q == REG_DATA) && !tx_full;
    assign tx_flush = wr_commit && (addr_q == REG_CTRL) && din_q[CTRL_FLUSH];
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_commit && (addr_q == REG_DATA) && rx_seen_q;

    always_comb begin
        status_byte            = '0;
        status_byte[ST_RX_NE]  = !rx_empty;
        status_byte[ST_TX_NF]  = !tx_full;
        status_byte[ST_TX_OVR] = tx_ovr_q;
        status_byte[ST_RX_UNF] = rx_unf_q;
        status_byte[ST_IRQ]    = irq_q;
        bank_byte                      = '0;
        bank_byte[ROM_BANK_BITS-1:0]   = bank_q;
        case (a_s2_q)
            REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_mux = status_byte;
            REG_CTRL:   rd_mux = {6'b0, ie_q};
            default:    rd_mux = bank_byte;
        endcase
    end

    assign irq_d = (ie_q[CTRL_RX_IE] && !rx_empty) || (ie_q[CTRL_TX_IE] && !tx_full);

    always_ff @(posedge SYSCLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            din_q     <= '0;
            dout_q    <= '0;
            rx_seen_q <= 1'b0;
            ie_q      <= '0;
            bank_q    <= '0;
            tx_ovr_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            if (state_d == ACTIVE) begin
                addr_q    <= a_s2_q;
                rw_q      <= rw_s2_q;
                din_q     <= din_s2_q;
                dout_q    <= rd_mux;
                rx_seen_q <= !rx_empty;
            end
            if (wr_commit && (addr_q == REG_CTRL)) begin
                ie_q <= {din_q[CTRL_TX_IE], din_q[CTRL_RX_IE]};
            end
            if (wr_commit && (addr_q == REG_BANK)) begin
                bank_q <= din_q[ROM_BANK_BITS-1:0];
            end
            if (wr_commit && (addr_q == REG_DATA) && tx_full) begin
                tx_ovr_q <= 1'b1;
            end else if (rd_commit && (addr_q == REG_STATUS)) begin
                tx_ovr_q <= 1'b0;
            end
            if (rd_commit && (addr_q == REG_DATA) && !rx_seen_q) begin
                rx_unf_q <= 1'b1;
            end else if (rd_commit && (addr_q == REG_STATUS)) begin
                rx_unf_q <= 1'b0;
            end
        end
    end

    slot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (SYSCLK),
        .rst_n   (nRST),
        .push_i  (tx_push),
        .wdata_i (din_q),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    slot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (SYSCLK),
        .rst_n   (nRST),
        .push_i  (rx_push),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .flush_i (tx_flush),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign unused_counts = ^{tx_count, rx_count};

    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_full;
    assign CPU_D_OE  = (state_q == ACTIVE) && rw_q;
    assign CPU_D_OUT = dout_q;
    assign nIRQ      = !irq_q;
    assign ROM_A     = {bank_q, CPU_A};
    assign ROM_nCE   = !SLOT_ROMSEL;

endmodule
